traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIME_W, 5, phase counter width.
- RED_T, 11, red duration in ticks.
- GREEN_T, 10, green duration in ticks.
- YELLOW_T, 3, yellow duration in ticks.
- MIN_GREEN, 4, minimum green ticks before a pedestrian request may end green.
- WALK_T, 8, walk-signal ticks at start of red.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- roll, in, 1, one-cycle tick enable; timing advances only on cycles where roll=1.
- btn, in, 1, pedestrian button level, synchronous to clk.
- flash, in, 1, level; requests flashing-yellow fault mode.
- sw_traffic_lights, out, 2, light code: 01 red, 10 green, 11 yellow, 00 off.
- walk, out, 1, pedestrian walk indication.
- ped_pending, out, 1, latched pedestrian request not yet served.
- phase_remaining, out, TIME_W, ticks left in the current phase, including the current tick.

Function
REQ-003 The FSM SHALL have exactly these states: RED, GREEN, YELLOW and FLASH.
REQ-004 The phase counter cnt SHALL run from 0 to DUR-1 of the current phase and advance only on roll=1.
REQ-005 On a roll with cnt=DUR-1, the FSM SHALL move to the next phase and clear cnt to 0; the phase order is RED->GREEN->YELLOW->RED.
REQ-006 All outputs SHALL be registered and SHALL change on the same edge as the state/cnt update, giving zero extra latency after the roll cycle.
REQ-007 A rising edge of btn (btn=1, previous btn=0) SHALL set ped_pending; a held btn SHALL NOT re-trigger.
REQ-008 In GREEN, a roll with ped_pending=1 and cnt>=MIN_GREEN-1 SHALL move the FSM to YELLOW with cnt=0, ending green early.
REQ-009 In GREEN with cnt<MIN_GREEN-1, a pending request SHALL wait; the early exit SHALL occur on the first qualifying roll.
REQ-010 ped_pending SHALL clear on the edge that enters RED; if a btn rising edge coincides with that edge, the clear SHALL win.
REQ-011 A btn edge in RED or YELLOW SHALL set ped_pending, which then applies in the next GREEN.
REQ-012 walk SHALL be 1 iff state=RED and cnt<WALK_T.
REQ-013 phase_remaining SHALL equal DUR-cnt in the timed phases and 0 in FLASH.
REQ-014 A roll with flash=1 SHALL enter FLASH from any state, with cnt=0 and sw_traffic_lights=11; this has priority over every other transition.
REQ-015 In FLASH, each roll SHALL toggle sw_traffic_lights between 11 and 00, and walk SHALL be 0.
REQ-016 In FLASH, a roll with flash=0 SHALL exit to RED with cnt=0; ped_pending is retained through FLASH but clears on RED entry per REQ-010.
REQ-017 Without roll, no state, cnt or light change SHALL occur, although ped_pending still latches btn edges.
REQ-018 Elaboration SHALL fail if any duration is 0, any duration exceeds 2^TIME_W-1, MIN_GREEN>GREEN_T, or WALK_T>RED_T.
REQ-019 The counter SHALL never wrap past DUR-1; arithmetic SHALL be unsigned TIME_W-bit.

Reset
REQ-020 While reset=1 on a clk edge, the block SHALL load state=RED, cnt=0, sw_traffic_lights=01, walk=1 (WALK_T>0), ped_pending=0, phase_remaining=RED_T, and clear the btn history to 0.
REQ-021 Reset SHALL override roll, btn and flash on the same edge; reset mid-phase or mid-FLASH SHALL restart at the RED cnt=0 state.

Structure
REQ-022 The phase enum and the light-code constants (RED=01, GREEN=10, YELLOW=11, OFF=00) SHALL live in the shared package traffic_pkg.
REQ-023 The btn rising-edge detect-and-latch SHALL be one sub-module, btn_req_latch, with ports clk, reset, btn, clr, pending.

Verification
REQ-024 The bench SHALL cover these directed scenarios with default parameters:
- Reset, then 24 rolls with no btn -> lights 01 x11, 10 x10, 11 x3, then 01; walk high for the first 8 RED rolls only.
- btn pulse at GREEN cnt=1 -> ped_pending=1; on the roll at cnt=3, lights go to 11; at RED entry ped_pending goes to 0.
- btn held high across 3 full cycles -> exactly one request latched per rising edge; no early exit in later cycles.
- flash=1 at YELLOW cnt=1 on a roll -> lights 11, then 00 and 11 alternating per roll; flash=0 on a roll -> lights 01, phase_remaining=11.
- reset=1 asserted at GREEN cnt=6 together with roll and btn -> next cycle RED, cnt=0, ped_pending=0.
- btn edge on the same cycle as the YELLOW->RED roll -> ped_pending=0 afterwards.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic phase controller.
//   phase_t      - controller phases (RED, GREEN, YELLOW, FLASH)
//   LIGHT_*      - two-bit lamp codes driven on sw_traffic_lights
//   light_code() - lamp code shown for a timed phase
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } phase_t;

  localparam logic [1:0] LIGHT_OFF    = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW = 2'b11;

  // FLASH has no fixed code (it toggles); callers handle it separately.
  function automatic logic [1:0] light_code(input phase_t p);
    case (p)
      ST_RED:    light_code = LIGHT_RED;
      ST_GREEN:  light_code = LIGHT_GREEN;
      ST_YELLOW: light_code = LIGHT_YELLOW;
      default:   light_code = LIGHT_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/btn_req_latch.sv
// btn_req_latch: pedestrian button rising-edge detector with request latch.
//   clk     - clock
//   reset   - synchronous active-high reset (clears history and request)
//   btn     - button level, synchronous to clk
//   clr     - clears the request; wins over a coincident rising edge
//   pending - latched request
module btn_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic pending
);

  logic btn_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      btn_prev <= btn;
      if (clr)
        pending <= 1'b0;
      else if (btn && !btn_prev)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: RED->GREEN->YELLOW traffic light sequencer with
// pedestrian early-exit from GREEN and a flashing-yellow fault mode.
//   clk               - clock
//   reset             - synchronous active-high reset
//   roll              - tick enable; phase timing advances only when 1
//   btn               - pedestrian button level
//   flash             - requests flashing-yellow mode (acted on at a roll)
//   sw_traffic_lights - lamp code (01 red, 10 green, 11 yellow, 00 off)
//   walk              - pedestrian walk indication
//   ped_pending       - latched pedestrian request not yet served
//   phase_remaining   - ticks left in the current phase (0 in FLASH)
// All outputs are registered and computed from the next state so they
// change on the same edge as the state/counter.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TIME_W    = 5,
  parameter int RED_T     = 11,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int MIN_GREEN = 4,
  parameter int WALK_T    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              roll,
  input  logic              btn,
  input  logic              flash,
  output logic [1:0]        sw_traffic_lights,
  output logic              walk,
  output logic              ped_pending,
  output logic [TIME_W-1:0] phase_remaining
);

  localparam int MAX_T = (1 << TIME_W) - 1;

  if (RED_T < 1 || GREEN_T < 1 || YELLOW_T < 1 || MIN_GREEN < 1 ||
      RED_T > MAX_T || GREEN_T > MAX_T || YELLOW_T > MAX_T ||
      MIN_GREEN > MAX_T || WALK_T > MAX_T ||
      MIN_GREEN > GREEN_T || WALK_T > RED_T) begin : g_bad_params
    $error("traffic_phase_ctrl: illegal timing parameters");
  end

  localparam logic [TIME_W-1:0] ONE        = TIME_W'(1);
  localparam logic [TIME_W-1:0] RED_D      = TIME_W'(RED_T);
  localparam logic [TIME_W-1:0] GREEN_D    = TIME_W'(GREEN_T);
  localparam logic [TIME_W-1:0] YELLOW_D   = TIME_W'(YELLOW_T);
  localparam logic [TIME_W-1:0] RED_LAST   = TIME_W'(RED_T - 1);
  localparam logic [TIME_W-1:0] GREEN_LAST = TIME_W'(GREEN_T - 1);
  localparam logic [TIME_W-1:0] YEL_LAST   = TIME_W'(YELLOW_T - 1);
  localparam logic [TIME_W-1:0] MIN_LAST   = TIME_W'(MIN_GREEN - 1);
  localparam logic [TIME_W-1:0] WALK_LIM   = TIME_W'(WALK_T);

  phase_t            state, state_next;
  logic [TIME_W-1:0] cnt, cnt_next;
  logic [1:0]        lights_next;
  logic              walk_next;
  logic [TIME_W-1:0] remaining_next;
  logic              clr;

  // Request is served when RED is entered (from YELLOW or FLASH).
  assign clr = roll && (state_next == ST_RED) && (state != ST_RED);

  btn_req_latch u_btn_req_latch (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .clr     (clr),
    .pending (ped_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_RED;
      cnt               <= '0;
      sw_traffic_lights <= LIGHT_RED;
      walk              <= (WALK_T > 0);
      phase_remaining   <= RED_D;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      sw_traffic_lights <= lights_next;
      walk              <= walk_next;
      phase_remaining   <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    lights_next    = sw_traffic_lights;
    walk_next      = 1'b0;
    remaining_next = '0;

    if (roll) begin
      if (flash) begin
        // Fault mode overrides every other transition.
        cnt_next = '0;
        if (state == ST_FLASH) begin
          lights_next = (sw_traffic_lights == LIGHT_OFF) ? LIGHT_YELLOW : LIGHT_OFF;
        end else begin
          state_next  = ST_FLASH;
          lights_next = LIGHT_YELLOW;
        end
      end else begin
        case (state)
          ST_RED: begin
            if (cnt == RED_LAST) begin
              state_next = ST_GREEN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + ONE;
            end
          end
          ST_GREEN: begin
            // Pedestrian early exit once minimum green has been served.
            if ((ped_pending && cnt >= MIN_LAST) || cnt == GREEN_LAST) begin
              state_next = ST_YELLOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + ONE;
            end
          end
          ST_YELLOW: begin
            if (cnt == YEL_LAST) begin
              state_next = ST_RED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + ONE;
            end
          end
          default: begin
            state_next = ST_RED;
            cnt_next   = '0;
          end
        endcase
      end
    end

    if (state_next != ST_FLASH)
      lights_next = light_code(state_next);

    walk_next = (state_next == ST_RED) && (cnt_next < WALK_LIM);

    case (state_next)
      ST_RED:    remaining_next = RED_D - cnt_next;
      ST_GREEN:  remaining_next = GREEN_D - cnt_next;
      ST_YELLOW: remaining_next = YELLOW_D - cnt_next;
      default:   remaining_next = '0;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios followed
// by random stimulus, every cycle compared against a phase/tick model.
module tb_traffic_phase_ctrl;

  localparam int TIME_W    = 5;
  localparam int MIN_GREEN = 4;
  localparam int WALK_T    = 8;

  logic              clk;
  logic              reset, roll, btn, flash;
  logic [1:0]        sw_traffic_lights;
  logic              walk, ped_pending;
  logic [TIME_W-1:0] phase_remaining;

  int errors = 0;
  int checks = 0;

  // Model: phase index 0 red, 1 green, 2 yellow, 3 flash.
  int  dur [3] = '{11, 10, 3};
  int  code[3] = '{1, 2, 3};
  int  m_ph, m_el;
  bit  m_pend, m_prev, m_fl_on;

  traffic_phase_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .roll              (roll),
    .btn               (btn),
    .flash             (flash),
    .sw_traffic_lights (sw_traffic_lights),
    .walk              (walk),
    .ped_pending       (ped_pending),
    .phase_remaining   (phase_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit rl, input bit b, input bit f);
    int  old_ph;
    bit  rise;
    if (rst) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_prev = 0; m_fl_on = 1;
      return;
    end
    old_ph = m_ph;
    if (rl) begin
      if (f) begin
        if (m_ph == 3) m_fl_on = !m_fl_on;
        else begin m_ph = 3; m_fl_on = 1; end
        m_el = 0;
      end else if (m_ph == 3) begin
        m_ph = 0; m_el = 0;
      end else if (m_ph == 1 && m_pend && m_el >= MIN_GREEN - 1) begin
        m_ph = 2; m_el = 0;
      end else if (m_el + 1 == dur[m_ph]) begin
        m_ph = (m_ph + 1) % 3; m_el = 0;
      end else begin
        m_el++;
      end
    end
    rise   = b && !m_prev;
    m_prev = b;
    if (m_ph == 0 && old_ph != 0) m_pend = 0;
    else if (rise)                m_pend = 1;
  endtask

  task automatic compare_model();
    int exp_l, exp_r;
    exp_l = (m_ph == 3) ? (m_fl_on ? 3 : 0) : code[m_ph];
    exp_r = (m_ph == 3) ? 0 : dur[m_ph] - m_el;
    check("lights",    32'(sw_traffic_lights), 32'(exp_l));
    check("walk",      32'(walk),              32'(m_ph == 0 && m_el < WALK_T));
    check("pending",   32'(ped_pending),       32'(m_pend));
    check("remaining", 32'(phase_remaining),   32'(exp_r));
  endtask

  // Apply one cycle of inputs, sample just after the edge, compare.
  task automatic cycle(input bit rst, input bit rl, input bit b, input bit f);
    reset = rst; roll = rl; btn = b; flash = f;
    @(posedge clk);
    #1;
    model_step(rst, rl, b, f);
    compare_model();
    $display("cyc rst=%0b roll=%0b btn=%0b flash=%0b -> lights=%02b walk=%0b pend=%0b rem=%0d",
             rst, rl, b, f, sw_traffic_lights, walk, ped_pending, phase_remaining);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
  endtask

  initial begin
    int exp_l;
    reset = 1'b1; roll = 1'b0; btn = 1'b0; flash = 1'b0;

    // Reset state and a full undisturbed cycle.
    do_reset();
    check("rst_lights", 32'(sw_traffic_lights), 32'd1);
    check("rst_walk",   32'(walk),              32'd1);
    check("rst_rem",    32'(phase_remaining),   32'd11);
    check("rst_pend",   32'(ped_pending),       32'd0);
    for (int k = 1; k <= 24; k++) begin
      cycle(0, 1, 0, 0);
      exp_l = (k <= 10) ? 1 : (k <= 20) ? 2 : (k <= 23) ? 3 : 1;
      check("seq_lights", 32'(sw_traffic_lights), 32'(exp_l));
      check("seq_walk",   32'(walk),              32'(k < 8 || k == 24));
    end

    // Pedestrian pulse at GREEN cnt=1 ends green at cnt=3.
    do_reset();
    for (int k = 0; k < 12; k++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    check("ped_latched", 32'(ped_pending), 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("ped_green_cnt3", 32'(sw_traffic_lights), 32'd2);
    cycle(0, 1, 0, 0);
    check("ped_early_yel", 32'(sw_traffic_lights), 32'd3);
    check("ped_yel_rem",   32'(phase_remaining),   32'd3);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0);
    check("ped_red_lights", 32'(sw_traffic_lights), 32'd1);
    check("ped_red_clear",  32'(ped_pending),       32'd0);

    // Held button: one request only.
    do_reset();
    for (int k = 0; k < 72; k++) cycle(0, 1, 1, 0);
    check("held_pend", 32'(ped_pending), 32'd0);

    // Flash entered from YELLOW cnt=1, toggles, exits to RED.
    do_reset();
    for (int k = 0; k < 22; k++) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    check("fl_enter", 32'(sw_traffic_lights), 32'd3);
    check("fl_rem",   32'(phase_remaining),   32'd0);
    cycle(0, 1, 0, 1);
    check("fl_off", 32'(sw_traffic_lights), 32'd0);
    cycle(0, 0, 0, 1);
    check("fl_hold", 32'(sw_traffic_lights), 32'd0);
    cycle(0, 1, 0, 1);
    check("fl_on", 32'(sw_traffic_lights), 32'd3);
    check("fl_walk", 32'(walk), 32'd0);
    cycle(0, 1, 0, 0);
    check("fl_exit_lights", 32'(sw_traffic_lights), 32'd1);
    check("fl_exit_rem",    32'(phase_remaining),   32'd11);

    // Reset mid-GREEN with roll and btn.
    do_reset();
    for (int k = 0; k < 17; k++) cycle(0, 1, 0, 0);
    check("mid_green", 32'(phase_remaining), 32'd4);
    cycle(1, 1, 1, 0);
    check("rst_mid_lights", 32'(sw_traffic_lights), 32'd1);
    check("rst_mid_rem",    32'(phase_remaining),   32'd11);
    check("rst_mid_pend",   32'(ped_pending),       32'd0);

    // Button edge coinciding with YELLOW->RED: clear wins.
    do_reset();
    for (int k = 0; k < 23; k++) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    check("coinc_lights", 32'(sw_traffic_lights), 32'd1);
    check("coinc_pend",   32'(ped_pending),       32'd0);

    // Random stimulus against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
